// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes,
// sequencer states and datapath mux select encodings.
package cpu_pkg;

    typedef enum logic [4:0] {
        HLT  = 5'b00000,
        STO  = 5'b00001,
        LD   = 5'b00010,
        LDI  = 5'b00011,
        ADD  = 5'b00100,
        ADDI = 5'b00101,
        SUB  = 5'b00110,
        SUBI = 5'b00111,
        BEQ  = 5'b01000,
        BNE  = 5'b01001,
        BGT  = 5'b01010,
        BGE  = 5'b01011,
        BLT  = 5'b01100,
        BLE  = 5'b01101,
        JMP  = 5'b01110
    } opcode_t;

    typedef enum logic [2:0] {
        RST, FETCH, DECODE, EXEC, MEM, HALT
    } state_t;

    localparam logic [1:0] SEL_A_ALU = 2'b00;
    localparam logic [1:0] SEL_A_MEM = 2'b01;
    localparam logic [1:0] SEL_A_IMM = 2'b10;
    localparam logic       SEL_B_MEM = 1'b0;
    localparam logic       SEL_B_IMM = 1'b1;

    // Opcodes that need a data memory access before they retire
    function automatic logic is_mem_op(input opcode_t op);
        return (op == STO) || (op == LD) || (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory signal bundle. The sequencer uses the
// slave view; whoever drives opcode, flags and ready lines uses master.
interface control_sequencer_if #(
    parameter int DATA_WIDTH        = 11,
    parameter int INSTRUCTION_WIDTH = 15,
    parameter int COUNT_WIDTH       = 16
);
    localparam int OPW = INSTRUCTION_WIDTH - DATA_WIDTH + 1;

    logic [OPW-1:0]         op_code;
    logic                   status_Z_in;
    logic                   status_N_in;
    logic                   imem_ready_in;
    logic                   dmem_ready_in;
    logic                   run_in;

    logic                   branch_out;
    logic [1:0]             sel_A_out;
    logic                   sel_B_out;
    logic                   alu_op_out;
    logic                   data_memory_wr_out;
    logic                   acc_wr_out;
    logic                   pc_wr_out;
    logic                   status_wr_out;
    logic                   ir_wr_out;
    logic                   acc_reset_out;
    logic                   pc_reset_out;
    logic                   status_reset_out;
    logic                   ir_reset_out;
    logic                   imem_req_out;
    logic                   dmem_req_out;
    logic                   halted_out;
    logic                   illegal_out;
    logic [COUNT_WIDTH-1:0] retired_count_out;

    modport slave (
        input  op_code, status_Z_in, status_N_in, imem_ready_in, dmem_ready_in, run_in,
        output branch_out, sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out,
               acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out,
               acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out,
               imem_req_out, dmem_req_out, halted_out, illegal_out, retired_count_out
    );

    modport master (
        output op_code, status_Z_in, status_N_in, imem_ready_in, dmem_ready_in, run_in,
        input  branch_out, sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out,
               acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out,
               acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out,
               imem_req_out, dmem_req_out, halted_out, illegal_out, retired_count_out
    );

endinterface

// File: rtl/control_sequencer_branch_condition.sv
// Branch resolution from the STATUS flags. Non-branch opcodes never take.
module branch_condition
    import cpu_pkg::*;
(
    input  opcode_t op_code,
    input  logic    Z,
    input  logic    N,
    output logic    taken
);

    // Flag condition per branch opcode; JMP is unconditional
    always_comb begin
        taken = 1'b0;
        case (op_code)
            BEQ:     taken = Z;
            BNE:     taken = !Z;
            BGT:     taken = !Z && !N;
            BGE:     taken = !N;
            BLT:     taken = N;
            BLE:     taken = N || Z;
            JMP:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Outputs are decoded combinationally from the registered state, the
// opcode, the flags and the ready lines, so a ready completes an access
// in the same cycle and reset drops requests without waiting for a clock.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH        = 11,
    parameter int INSTRUCTION_WIDTH = 15,
    parameter int COUNT_WIDTH       = 16
) (
    input logic                clock_in,
    input logic                reset_in,
    control_sequencer_if.slave bus
);

    localparam int OPW = INSTRUCTION_WIDTH - DATA_WIDTH + 1;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [OPW-1:0]         w_op_raw;
    opcode_t                w_op;
    logic                   w_taken;
    logic                   w_retire;

    assign w_op_raw = bus.op_code;
    assign w_op     = opcode_t'(w_op_raw);

    branch_condition u_branch (
        .op_code (w_op),
        .Z       (bus.status_Z_in),
        .N       (bus.status_N_in),
        .taken   (w_taken)
    );

    // An instruction retires when it completes: MEM on ready, any EXEC, or HLT at decode
    assign w_retire = ((r_state == MEM) && bus.dmem_ready_in) ||
                      (r_state == EXEC) ||
                      ((r_state == DECODE) && (w_op == HLT));

    // State sequencing; RST is held for one extra cycle after reset release
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= RST;
        end else begin
            case (r_state)
                RST:     r_state <= FETCH;
                FETCH:   if (bus.imem_ready_in) r_state <= DECODE;
                DECODE: begin
                    if (w_op == HLT)         r_state <= HALT;
                    else if (is_mem_op(w_op)) r_state <= MEM;
                    else                      r_state <= EXEC;
                end
                MEM:     if (bus.dmem_ready_in) r_state <= FETCH;
                EXEC:    r_state <= FETCH;
                HALT:    if (bus.run_in) r_state <= FETCH;
                default: r_state <= RST;
            endcase
        end
    end

    // Retired-instruction counter, saturating at all-ones
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in)                      r_count <= '0;
        else if (w_retire && r_count != '1) r_count <= r_count + COUNT_WIDTH'(1);
    end

    assign bus.retired_count_out = r_count;

    // Control decode: everything defaults low, each state raises only what it needs
    always_comb begin
        bus.branch_out         = 1'b0;
        bus.sel_A_out          = SEL_A_ALU;
        bus.sel_B_out          = SEL_B_MEM;
        bus.alu_op_out         = 1'b0;
        bus.data_memory_wr_out = 1'b0;
        bus.acc_wr_out         = 1'b0;
        bus.pc_wr_out          = 1'b0;
        bus.status_wr_out      = 1'b0;
        bus.ir_wr_out          = 1'b0;
        bus.acc_reset_out      = 1'b0;
        bus.pc_reset_out       = 1'b0;
        bus.status_reset_out   = 1'b0;
        bus.ir_reset_out       = 1'b0;
        bus.imem_req_out       = 1'b0;
        bus.dmem_req_out       = 1'b0;
        bus.halted_out         = 1'b0;
        bus.illegal_out        = 1'b0;
        case (r_state)
            RST: begin
                bus.acc_reset_out    = 1'b1;
                bus.pc_reset_out     = 1'b1;
                bus.status_reset_out = 1'b1;
                bus.ir_reset_out     = 1'b1;
            end
            FETCH: begin
                bus.imem_req_out = 1'b1;
                bus.ir_wr_out    = bus.imem_ready_in;
            end
            MEM: begin
                bus.dmem_req_out       = 1'b1;
                bus.data_memory_wr_out = (w_op == STO);
                if (bus.dmem_ready_in) begin
                    bus.pc_wr_out = 1'b1;
                    case (w_op)
                        LD: begin
                            bus.acc_wr_out    = 1'b1;
                            bus.status_wr_out = 1'b1;
                            bus.sel_A_out     = SEL_A_MEM;
                        end
                        ADD, SUB: begin
                            bus.acc_wr_out    = 1'b1;
                            bus.status_wr_out = 1'b1;
                            bus.sel_A_out     = SEL_A_ALU;
                            bus.sel_B_out     = SEL_B_MEM;
                            bus.alu_op_out    = (w_op == SUB);
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                bus.pc_wr_out = 1'b1;
                case (w_op)
                    LDI: begin
                        bus.acc_wr_out    = 1'b1;
                        bus.status_wr_out = 1'b1;
                        bus.sel_A_out     = SEL_A_IMM;
                    end
                    ADDI, SUBI: begin
                        bus.acc_wr_out    = 1'b1;
                        bus.status_wr_out = 1'b1;
                        bus.sel_A_out     = SEL_A_ALU;
                        bus.sel_B_out     = SEL_B_IMM;
                        bus.alu_op_out    = (w_op == SUBI);
                    end
                    BEQ, BNE, BGT, BGE, BLT, BLE, JMP: bus.branch_out = w_taken;
                    // Memory opcodes and HLT never reach EXEC
                    HLT, STO, LD, ADD, SUB: ;
                    default: bus.illegal_out = 1'b1;
                endcase
            end
            HALT: begin
                bus.halted_out = 1'b1;
                bus.pc_wr_out  = bus.run_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. The driver issues one input
// vector per cycle and queues the hand-computed expected outputs; a
// negedge monitor pops and compares against what the DUT presents.
module tb_control_sequencer;

    localparam logic [15:0] F_RES  = 16'hF000;
    localparam logic [15:0] F_IMR  = 16'h0800;
    localparam logic [15:0] F_IRW  = 16'h0400;
    localparam logic [15:0] F_DMR  = 16'h0200;
    localparam logic [15:0] F_DWR  = 16'h0100;
    localparam logic [15:0] F_ACCW = 16'h0080;
    localparam logic [15:0] F_STW  = 16'h0040;
    localparam logic [15:0] F_PCW  = 16'h0020;
    localparam logic [15:0] F_BR   = 16'h0010;
    localparam logic [15:0] F_SB   = 16'h0008;
    localparam logic [15:0] F_AOP  = 16'h0004;
    localparam logic [15:0] F_HALT = 16'h0002;
    localparam logic [15:0] F_ILL  = 16'h0001;

    typedef struct {
        string       nm;
        logic [15:0] fl;
        logic [1:0]  sa;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    exp_t e;
    logic [15:0] af;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] cnt = 16'd0;

    control_sequencer_if #(.DATA_WIDTH(11), .INSTRUCTION_WIDTH(15), .COUNT_WIDTH(16)) bus();

    control_sequencer #(.DATA_WIDTH(11), .INSTRUCTION_WIDTH(15), .COUNT_WIDTH(16)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare the full output vector each cycle an expectation is pending
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e  = q.pop_front();
            af = {bus.acc_reset_out, bus.pc_reset_out, bus.status_reset_out, bus.ir_reset_out,
                  bus.imem_req_out, bus.ir_wr_out, bus.dmem_req_out, bus.data_memory_wr_out,
                  bus.acc_wr_out, bus.status_wr_out, bus.pc_wr_out, bus.branch_out,
                  bus.sel_B_out, bus.alu_op_out, bus.halted_out, bus.illegal_out};
            n_cmp++;
            if (af !== e.fl || bus.sel_A_out !== e.sa || bus.retired_count_out !== e.cnt) begin
                n_bad++;
                $display("FAIL %s: got flags=%h selA=%b cnt=%0d, want flags=%h selA=%b cnt=%0d",
                         e.nm, af, bus.sel_A_out, bus.retired_count_out, e.fl, e.sa, e.cnt);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [4:0] op,
                        input logic z, input logic n, input logic ir, input logic dr,
                        input logic run, input logic [15:0] fl, input logic [1:0] sa,
                        input logic [15:0] c);
        exp_t x;
        @(posedge clk);
        #1;
        rst               = r;
        bus.op_code       = op;
        bus.status_Z_in   = z;
        bus.status_N_in   = n;
        bus.imem_ready_in = ir;
        bus.dmem_ready_in = dr;
        bus.run_in        = run;
        x.nm = nm; x.fl = fl; x.sa = sa; x.cnt = c;
        q.push_back(x);
    endtask

    // Ready-high instruction: FETCH, DECODE, then the EXEC/MEM completion cycle
    task automatic instr(input string nm, input logic [4:0] op, input logic z, input logic n,
                         input logic [15:0] fin, input logic [1:0] sa);
        step({nm, "/F"}, 1'b0, op, z, n, 1'b1, 1'b1, 1'b0, F_IMR | F_IRW, 2'b00, cnt);
        step({nm, "/D"}, 1'b0, op, z, n, 1'b1, 1'b1, 1'b0, 16'h0000,      2'b00, cnt);
        step({nm, "/X"}, 1'b0, op, z, n, 1'b1, 1'b1, 1'b0, fin,           sa,    cnt);
        cnt = cnt + 16'd1;
    endtask

    // Branch taken table indexed by {Z,N}, BEQ..JMP
    logic [3:0] tmask [7] = '{4'b1100, 4'b0011, 4'b0001, 4'b0101, 4'b1010, 4'b1110, 4'b1111};

    initial begin
        logic [1:0] znb;
        bus.op_code = 5'd0; bus.status_Z_in = 1'b0; bus.status_N_in = 1'b0;
        bus.imem_ready_in = 1'b0; bus.dmem_ready_in = 1'b0; bus.run_in = 1'b0;

        // Reset held, then one extra RST cycle after release
        step("rst0",   1'b1, 5'd0, 0, 0, 1, 1, 1, F_RES, 2'b00, 16'd0);
        step("rst1",   1'b1, 5'd0, 0, 0, 1, 1, 1, F_RES, 2'b00, 16'd0);
        step("rstrel", 1'b0, 5'd0, 0, 0, 1, 1, 1, F_RES, 2'b00, 16'd0);

        instr("ldi", 5'b00011, 0, 0, F_ACCW | F_STW | F_PCW, 2'b10);

        // ADD with two data-memory wait cycles; ready/run in DECODE are ignored
        step("add/F",  1'b0, 5'b00100, 0, 0, 1, 0, 0, F_IMR | F_IRW, 2'b00, cnt);
        step("add/D",  1'b0, 5'b00100, 0, 0, 1, 1, 1, 16'h0000,      2'b00, cnt);
        step("add/W1", 1'b0, 5'b00100, 0, 0, 0, 0, 0, F_DMR,         2'b00, cnt);
        step("add/W2", 1'b0, 5'b00100, 0, 0, 0, 0, 0, F_DMR,         2'b00, cnt);
        step("add/M",  1'b0, 5'b00100, 0, 0, 0, 1, 0, F_DMR | F_ACCW | F_STW | F_PCW, 2'b00, cnt);
        cnt = cnt + 16'd1;

        instr("sto",  5'b00001, 0, 0, F_DMR | F_DWR | F_PCW, 2'b00);
        instr("ld",   5'b00010, 0, 0, F_DMR | F_ACCW | F_STW | F_PCW, 2'b01);
        instr("sub",  5'b00110, 0, 0, F_DMR | F_ACCW | F_STW | F_PCW | F_AOP, 2'b00);
        instr("addi", 5'b00101, 0, 0, F_ACCW | F_STW | F_PCW | F_SB, 2'b00);
        instr("subi", 5'b00111, 0, 0, F_ACCW | F_STW | F_PCW | F_SB | F_AOP, 2'b00);

        // Branch sweep over all flag combinations
        for (int zn = 0; zn < 4; zn++) begin
            znb = 2'(zn);
            for (int k = 0; k < 7; k++) begin
                instr($sformatf("br%0d_zn%0d", k, zn), 5'(8 + k), znb[1], znb[0],
                      F_PCW | (tmask[k][znb] ? F_BR : 16'h0000), 2'b00);
            end
        end

        // HLT retires at decode, idles in HALT ignoring readies, resumes on run
        step("hlt/F", 1'b0, 5'b00000, 1, 0, 1, 1, 0, F_IMR | F_IRW, 2'b00, cnt);
        step("hlt/D", 1'b0, 5'b00000, 1, 0, 1, 1, 0, 16'h0000,      2'b00, cnt);
        cnt = cnt + 16'd1;
        for (int i = 0; i < 5; i++)
            step($sformatf("hlt/H%0d", i), 1'b0, 5'b00000, 1, 0, i[0], i[0], 0, F_HALT, 2'b00, cnt);
        step("hlt/run", 1'b0, 5'b00000, 1, 0, 0, 0, 1, F_HALT | F_PCW, 2'b00, cnt);
        step("hlt/F2",  1'b0, 5'b00011, 0, 0, 0, 0, 0, F_IMR,          2'b00, cnt);
        step("hlt/F3",  1'b0, 5'b00011, 0, 0, 1, 0, 0, F_IMR | F_IRW,  2'b00, cnt);
        step("hlt/D3",  1'b0, 5'b00011, 0, 0, 0, 0, 0, 16'h0000,       2'b00, cnt);
        step("hlt/X3",  1'b0, 5'b00011, 0, 0, 0, 0, 0, F_ACCW | F_STW | F_PCW, 2'b10, cnt);
        cnt = cnt + 16'd1;

        // Undefined opcode, then reset in the middle of a fetch wait
        instr("ill", 5'b10110, 0, 0, F_PCW | F_ILL, 2'b00);
        step("ill/W1",  1'b0, 5'b10110, 0, 0, 0, 0, 0, F_IMR, 2'b00, cnt);
        step("ill/W2",  1'b0, 5'b10110, 0, 0, 0, 0, 0, F_IMR, 2'b00, cnt);
        cnt = 16'd0;
        step("mid/rst", 1'b1, 5'b10110, 0, 0, 1, 1, 0, F_RES, 2'b00, cnt);
        step("mid/rs2", 1'b1, 5'b10110, 0, 0, 1, 1, 0, F_RES, 2'b00, cnt);
        step("mid/rel", 1'b0, 5'b00011, 0, 0, 1, 1, 0, F_RES, 2'b00, cnt);
        step("mid/F",   1'b0, 5'b00011, 0, 0, 1, 1, 0, F_IMR | F_IRW, 2'b00, cnt);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/decode/execute controller for the 5-bit-opcode accumulator CPU. It sequences the PC, IR, ACC and STATUS register enables, the ALU and operand muxes, and the instruction/data memory request handshakes. It also tracks the halt state and counts retired instructions. It sits between the IR opcode field and the datapath, taking over sequencing from the single-cycle decoder.

## Interface
- DATA_WIDTH, 11: datapath operand width; sets opcode width.
- INSTRUCTION_WIDTH, 15: instruction width; opcode is `[INSTRUCTION_WIDTH-DATA_WIDTH:0]`, 5 bits at defaults.
- COUNT_WIDTH, 16: width of the retired-instruction counter.
- clock_in  in  1  sole clock; all state updates on its rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- op_code  in  INSTRUCTION_WIDTH-DATA_WIDTH+1  opcode from the IR; valid from DECODE onward.
- status_Z_in, status_N_in  in  1 each  STATUS register zero and negative flags.
- imem_ready_in  in  1  instruction memory has the word; IR captures it on this edge.
- dmem_ready_in  in  1  data memory access complete; read data is valid in this cycle.
- run_in  in  1  resume from HALT.
- branch_out  out  1  PC loads the operand target instead of PC+1.
- sel_A_out  out  2  ACC input: 00 ALU result, 01 data memory, 10 immediate.
- sel_B_out  out  1  ALU operand B: 0 data memory, 1 immediate.
- alu_op_out  out  1  0 add, 1 subtract.
- data_memory_wr_out  out  1  write strobe, qualified by dmem_req_out.
- acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out  out  1 each  register write enables.
- acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out  out  1 each  register clears.
- imem_req_out, dmem_req_out  out  1 each  memory requests, held until the matching ready.
- halted_out  out  1  high in HALT.
- illegal_out  out  1  one-cycle pulse on an undefined opcode.
- retired_count_out  out  COUNT_WIDTH  number of completed instructions; saturating.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, HALT.
- Reset:
  - While reset_in is high, the state is RST, the counter is 0, all four `*_reset_out` are 1, and all other outputs are 0.
  - RST lasts one more cycle after release, with the resets still asserted, then goes to FETCH.
- FETCH:
  - imem_req_out=1.
  - When imem_ready_in=1: ir_wr_out=1 that cycle, then DECODE. Otherwise stay in FETCH.
- DECODE: one cycle, no enables asserted.
  - HLT(00000) goes to HALT.
  - STO(00001), LD(00010), ADD(00100) and SUB(00110) go to MEM.
  - All other opcodes go to EXEC.
- MEM:
  - dmem_req_out=1; data_memory_wr_out=1 only for STO.
  - When dmem_ready_in=1, pc_wr_out=1 and the state returns to FETCH. For LD/ADD/SUB, the same cycle also asserts acc_wr_out=1 and status_wr_out=1:
    - LD: sel_A=01.
    - ADD: sel_A=00, sel_B=0, alu_op=0.
    - SUB: sel_A=00, sel_B=0, alu_op=1.
  - Otherwise stay in MEM.
- EXEC: one cycle with pc_wr_out=1, then FETCH.
  - LDI(00011): acc_wr=1, status_wr=1, sel_A=10.
  - ADDI(00101): acc_wr=1, status_wr=1, sel_A=00, sel_B=1, alu_op=0.
  - SUBI(00111): acc_wr=1, status_wr=1, sel_A=00, sel_B=1, alu_op=1.
  - branch_out is 1 on taken branches and always on JMP(01110):
    - BEQ(01000): Z
    - BNE(01001): !Z
    - BGT(01010): !Z&&!N
    - BGE(01011): !N
    - BLT(01100): N
    - BLE(01101): N||Z
  - Opcodes 01111–11111 (undefined): PC+1 only, plus illegal_out=1.
- HALT:
  - halted_out=1; no enables asserted.
  - run_in=1 gives pc_wr_out=1 with branch_out=0 that cycle (steps past the HLT), then FETCH.
- retired_count_out increments by one on:
  - the MEM completion cycle;
  - every EXEC cycle, undefined opcodes included;
  - the DECODE cycle of a HLT.
  - It holds at all-ones once reached.
- Any output not listed for a state is 0.

## Timing
- Outputs are a combinational function of the registered state, op_code, the flags and the ready inputs (Mealy on the ready signals).
- With ready tied high, every instruction takes 3 cycles: FETCH, DECODE, EXEC or MEM. Each wait cycle adds one.
- The branch condition uses flags in the EXEC cycle. STATUS cannot change between DECODE and EXEC.
- A ready input outside its own request state is ignored.
- run_in outside HALT is ignored.
- reset_in asserted in any state, mid-wait included, forces RST immediately. Pending requests drop in the same cycle, without waiting for a clock edge.

## Structure
- Shared package cpu_pkg:
  - opcode enum (HLT..JMP);
  - state enum;
  - SEL_A_ALU/SEL_A_MEM/SEL_A_IMM and SEL_B_MEM/SEL_B_IMM constants.
- Sub-module branch_condition: combinational; inputs op_code, Z, N; output taken.
- The remainder is one FSM process plus the counter register.

## Test plan
- Reset then LDI with ready high: resets asserted during reset and for one cycle after release; then ir_wr in cycle 1, then acc_wr/status_wr/pc_wr with sel_A=10 in cycle 3.
- ADD with dmem_ready low for 2 cycles: dmem_req held 3 cycles; acc_wr/status_wr/pc_wr, sel_A=00, sel_B=0, alu_op=0 only in the ready cycle; retired count +1.
- STO: data_memory_wr=1 with dmem_req; acc_wr=0; pc_wr=1 on ready.
- Branch sweep over Z/N in {00,01,10,11}: BEQ/BNE/BGT/BGE/BLT/BLE branch_out matches the conditions; e.g. BGT with Z=0,N=0 gives branch_out=1, and BLE with Z=0,N=0 gives branch_out=0.
- HLT, idle 5 cycles, then run_in pulse: halted_out=1 throughout with no enables; on run, pc_wr=1, branch_out=0, then FETCH.
- Opcode 10110, then reset asserted mid-FETCH-wait: illegal_out pulses once with pc_wr; on reset, imem_req drops immediately and the counter is 0.
